// File: rtl/snes_pad_poller.sv
// SNES pad sequencer: periodic latch + 16 shift-clock pulses, samples the serial line and
// publishes a 12-bit active-low button word with a one-cycle valid strobe.
module snes_pad_poller #(
  parameter int POLL_DIV     = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_BIT     = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        poll_en,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] controller_state,
  output logic        state_valid,
  output logic        pad_present
);

  localparam int PMAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
  localparam int TW   = $clog2(POLL_DIV);
  localparam int PW   = $clog2(PMAX);

  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   phase;
  logic [PW-1:0]   phase_nxt;
  logic [3:0]      bit_idx;
  logic [3:0]      bit_idx_nxt;
  logic [TW-1:0]   timer;
  logic            data_meta;
  logic            data_sync;
  logic [15:0]     shift_reg;
  logic            sample_en;
  logic            publish;
  logic            latch_nxt;
  logic            sclk_nxt;

  // Next-state logic; pin levels are derived from the state being entered so
  // the registered pins switch on the same edge as the FSM.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase + 1'b1;
    bit_idx_nxt = bit_idx;
    sample_en   = 1'b0;

    case (state)
      ST_IDLE: begin
        phase_nxt = '0;
        if (timer == '0 && poll_en) begin
          state_nxt = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (phase == LATCH_LAST) begin
          state_nxt = ST_GAP;
          phase_nxt = '0;
        end
      end
      ST_GAP: begin
        if (phase == HALF_LAST) begin
          state_nxt   = ST_LOW;
          phase_nxt   = '0;
          bit_idx_nxt = 4'd0;
        end
      end
      ST_LOW: begin
        if (phase == HALF_LAST) begin
          sample_en = 1'b1;
          state_nxt = ST_HIGH;
          phase_nxt = '0;
        end
      end
      ST_HIGH: begin
        if (phase == HALF_LAST) begin
          phase_nxt = '0;
          if (bit_idx == 4'd15) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt   = ST_LOW;
            bit_idx_nxt = bit_idx + 4'd1;
          end
        end
      end
      ST_DONE: begin
        phase_nxt = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        phase_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase

    latch_nxt = (state_nxt == ST_LATCH);
    sclk_nxt  = (state_nxt != ST_LOW);
    publish   = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      phase   <= '0;
      bit_idx <= 4'd0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Free-running poll timer; poll_en only gates the launch, not the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= snes_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg        <= 16'h0000;
      snes_latch       <= 1'b0;
      snes_clk         <= 1'b1;
      controller_state <= 12'hFFF;
      state_valid      <= 1'b0;
      pad_present      <= 1'b0;
    end else begin
      snes_latch  <= latch_nxt;
      snes_clk    <= sclk_nxt;
      state_valid <= publish;
      if (sample_en) begin
        shift_reg[bit_idx] <= data_sync;
      end
      // An all-zero frame means a stuck-low line or no pad: report nothing pressed.
      if (publish) begin
        if (shift_reg == 16'h0000) begin
          controller_state <= 12'hFFF;
          pad_present      <= 1'b0;
        end else begin
          controller_state <= shift_reg[11:0];
          pad_present      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench for snes_pad_poller with a behavioural pad that shifts on rising snes_clk.
module tb_snes_pad_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_en;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [11:0] controller_state;
  logic        state_valid;
  logic        pad_present;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [15:0] pad_word = 16'hFFFF;
  logic        stuck = 1'b0;
  logic [4:0]  pad_idx = 5'd0;
  logic        sclk_d = 1'b1;

  snes_pad_poller #(
    .POLL_DIV(2000),
    .LATCH_CYCLES(12),
    .HALF_BIT(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .poll_en(poll_en),
    .snes_data(snes_data),
    .snes_latch(snes_latch),
    .snes_clk(snes_clk),
    .controller_state(controller_state),
    .state_valid(state_valid),
    .pad_present(pad_present)
  );

  always #5 clk = ~clk;

  // Pad: latch reloads bit 0, each rising shift clock presents the next bit.
  always @(posedge clk) begin
    sclk_d <= snes_clk;
    if (snes_latch) pad_idx <= 5'd0;
    else if (snes_clk && !sclk_d && pad_idx < 5'd16) pad_idx <= pad_idx + 5'd1;
  end
  assign snes_data = stuck ? 1'b0 : pad_word[pad_idx[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_latch(output int at);
    bit seen;
    at = -1;
    seen = 1'b0;
    for (int k = 0; k < 2500 && !seen; k++) begin
      tick();
      if (snes_latch) begin
        at = n;
        seen = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(output int at);
    bit seen;
    at = -1;
    seen = 1'b0;
    for (int k = 0; k < 2500 && !seen; k++) begin
      tick();
      if (state_valid) begin
        at = n;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    poll_en = 1'b0;
    repeat (3) tick();
    checks++; if (snes_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", snes_latch); end
    checks++; if (snes_clk !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b want 1", snes_clk); end
    checks++; if (controller_state !== 12'hFFF) begin errors++; $display("FAIL rst_state: got %h want fff", controller_state); end
    checks++; if (state_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", state_valid); end
    checks++; if (pad_present !== 1'b0) begin errors++; $display("FAIL rst_present: got %b want 0", pad_present); end
  endtask

  task automatic test_first_frame();
    int latch_err = 0, sclk_err = 0, valid_err = 0, vcount = 0, early = 0;
    logic exp_latch, exp_sclk, exp_valid;
    pad_word = 16'hFFEF;
    poll_en = 1'b1;
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 215; i++) begin
      tick();
      exp_latch = (n >= 1 && n <= 12);
      exp_sclk  = !(n >= 19 && n <= 210 && (((n - 19) / 6) % 2) == 0);
      exp_valid = (n == 211);
      if (snes_latch !== exp_latch) latch_err++;
      if (snes_clk !== exp_sclk) sclk_err++;
      if (state_valid !== exp_valid) valid_err++;
      if (state_valid === 1'b1) vcount++;
      if (n < 211 && controller_state !== 12'hFFF) early++;
    end
    checks++; if (latch_err != 0) begin errors++; $display("FAIL latch_wave: %0d bad cycles want 0", latch_err); end
    checks++; if (sclk_err != 0) begin errors++; $display("FAIL sclk_wave: %0d bad cycles want 0", sclk_err); end
    checks++; if (valid_err != 0) begin errors++; $display("FAIL valid_wave: %0d bad cycles want 0", valid_err); end
    checks++; if (vcount != 1) begin errors++; $display("FAIL valid_count: got %0d want 1", vcount); end
    checks++; if (early != 0) begin errors++; $display("FAIL early_update: %0d cycles changed want 0", early); end
    checks++; if (controller_state !== 12'hFEF) begin errors++; $display("FAIL word_up: got %h want fef", controller_state); end
    checks++; if (pad_present !== 1'b1) begin errors++; $display("FAIL present_up: got %b want 1", pad_present); end
  endtask

  task automatic test_second_frame();
    int at;
    pad_word = 16'hF7FF;
    wait_latch(at);
    checks++; if (at != 2001) begin errors++; $display("FAIL relaunch_time: got %0d want 2001", at); end
    wait_valid(at);
    checks++; if (at != 2211) begin errors++; $display("FAIL valid_time2: got %0d want 2211", at); end
    checks++; if (controller_state !== 12'h7FF) begin errors++; $display("FAIL word_r: got %h want 7ff", controller_state); end
    checks++; if (pad_present !== 1'b1) begin errors++; $display("FAIL present_r: got %b want 1", pad_present); end
  endtask

  task automatic test_reset_mid_frame();
    int at, vcount = 0;
    wait_latch(at);
    while (n < at + 104) tick();
    checks++; if (snes_clk !== 1'b0) begin errors++; $display("FAIL in_low7: sclk got %b want 0", snes_clk); end
    reset = 1'b1;
    tick();
    checks++; if (snes_clk !== 1'b1) begin errors++; $display("FAIL abort_sclk: got %b want 1", snes_clk); end
    checks++; if (snes_latch !== 1'b0) begin errors++; $display("FAIL abort_latch: got %b want 0", snes_latch); end
    checks++; if (controller_state !== 12'hFFF) begin errors++; $display("FAIL abort_state: got %h want fff", controller_state); end
    checks++; if (pad_present !== 1'b0) begin errors++; $display("FAIL abort_present: got %b want 0", pad_present); end
    if (state_valid === 1'b1) vcount++;
    repeat (5) begin
      tick();
      if (state_valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL abort_valid: got %0d pulses want 0", vcount); end
    pad_word = 16'hFDFE;
    reset = 1'b0;
    n = 0;
    wait_latch(at);
    checks++; if (at != 1) begin errors++; $display("FAIL post_rst_launch: got %0d want 1", at); end
    wait_valid(at);
    checks++; if (at != 211) begin errors++; $display("FAIL post_rst_valid: got %0d want 211", at); end
    checks++; if (controller_state !== 12'hDFE) begin errors++; $display("FAIL post_rst_word: got %h want dfe", controller_state); end
    checks++; if (pad_present !== 1'b1) begin errors++; $display("FAIL post_rst_present: got %b want 1", pad_present); end
  endtask

  task automatic test_stuck_low();
    int at;
    stuck = 1'b1;
    wait_valid(at);
    checks++; if (at != 2211) begin errors++; $display("FAIL stuck_valid: got %0d want 2211", at); end
    checks++; if (controller_state !== 12'hFFF) begin errors++; $display("FAIL stuck_word: got %h want fff", controller_state); end
    checks++; if (pad_present !== 1'b0) begin errors++; $display("FAIL stuck_present: got %b want 0", pad_present); end
  endtask

  task automatic test_poll_en_drop();
    int at, v, l2, rises = 0;
    stuck = 1'b0;
    pad_word = 16'h0FFE;
    wait_latch(at);
    checks++; if (at != 4001) begin errors++; $display("FAIL drop_launch: got %0d want 4001", at); end
    while (n < at + 49) tick();
    poll_en = 1'b0;
    wait_valid(v);
    checks++; if (v != at + 210) begin errors++; $display("FAIL drop_valid: got %0d want %0d", v, at + 210); end
    checks++; if (controller_state !== 12'hFFE) begin errors++; $display("FAIL drop_word: got %h want ffe", controller_state); end
    while (n < at + 2100) begin
      tick();
      if (snes_latch === 1'b1) rises++;
    end
    checks++; if (rises != 0) begin errors++; $display("FAIL drop_no_launch: got %0d latch cycles want 0", rises); end
    poll_en = 1'b1;
    wait_latch(l2);
    checks++; if (l2 != at + 4000) begin errors++; $display("FAIL reenable_launch: got %0d want %0d", l2, at + 4000); end
  endtask

  initial begin
    reset = 1'b1;
    poll_en = 1'b0;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_reset_mid_frame();
    test_stuck_low();
    test_poll_en_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
